// File: rtl/reg_bank_pkg.sv
// reg_bank_pkg: shared types and helpers for the parametrised register bank.
`default_nettype none

package reg_bank_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  localparam logic C_ZERO_BIT = 1'b0;

  function automatic logic is_valid_addr(input int unsigned addr, input int unsigned depth);
    return (addr < depth);
  endfunction

endpackage

`default_nettype wire

// File: rtl/reg_bank_read_port.sv
// reg_bank_read_port: zero/range/bypass select plus output register for one read port.
`default_nettype none

module reg_bank_read_port
  import reg_bank_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned DEPTH    = 32,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_en,
  input  logic [ADDR_W-1:0] i_sr,
  input  logic              i_wr_acc,
  input  logic [ADDR_W-1:0] i_dr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [DATA_W-1:0] i_mem_data,
  output logic [DATA_W-1:0] o_regd
);

  logic [DATA_W-1:0] w_nxt;
  logic [DATA_W-1:0] r_regd;

  // Zero register and out-of-range addresses win over the write bypass.
  always_comb begin
    w_nxt = {DATA_W{C_ZERO_BIT}};
    if (!i_en) begin
      w_nxt = {DATA_W{C_ZERO_BIT}};
    end else if (ZERO_REG && (i_sr == '0)) begin
      w_nxt = {DATA_W{C_ZERO_BIT}};
    end else if (!is_valid_addr(32'(i_sr), DEPTH)) begin
      w_nxt = {DATA_W{C_ZERO_BIT}};
    end else if (i_wr_acc && (i_dr == i_sr)) begin
      w_nxt = i_wdata;
    end else begin
      w_nxt = i_mem_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_regd <= {DATA_W{C_ZERO_BIT}};
    end else begin
      r_regd <= w_nxt;
    end
  end

  assign o_regd = r_regd;

endmodule

`default_nettype wire

// File: rtl/reg_bank_param.sv
// reg_bank_param: DEPTH x DATA_W register file, 2 registered read ports, 1 write port,
// post-reset clear sweep. Rev 1.0
`default_nettype none

module reg_bank_param
  import reg_bank_pkg::*;
#(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       ADDR_W    = 5,
  parameter int unsigned       DEPTH     = 32,
  parameter bit                ZERO_REG  = 1'b1,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] sr1,
  input  logic [ADDR_W-1:0] sr2,
  input  logic [ADDR_W-1:0] dr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              write,
  output logic [DATA_W-1:0] regd1,
  output logic [DATA_W-1:0] regd2,
  output logic              ready,
  output logic              wr_drop
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W:0]   r_clr_ptr;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              r_wr_drop;
  logic              w_ready;
  logic              w_clr_en;
  logic              w_clr_last;
  logic              w_dr_valid;
  logic              w_wr_acc;
  logic              w_drop_nxt;
  logic [DATA_W-1:0] w_rd1;
  logic [DATA_W-1:0] w_rd2;

  assign w_clr_last = (r_clr_ptr == (ADDR_W+1)'(DEPTH - 1));
  assign w_dr_valid = is_valid_addr(32'(dr), DEPTH);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= CLEAR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if ((r_state == CLEAR) && w_clr_last) begin
      w_state_nxt = READY;
    end
  end

  // A write to register 0 with ZERO_REG set is neither accepted nor reported.
  always_comb begin
    w_ready    = (r_state == READY);
    w_clr_en   = (r_state == CLEAR);
    w_wr_acc   = w_ready && write && w_dr_valid && !(ZERO_REG && (dr == '0));
    w_drop_nxt = write && (w_clr_en || !w_dr_valid);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_clr_ptr <= '0;
      r_wr_drop <= 1'b0;
    end else begin
      if (w_clr_en) begin
        r_clr_ptr <= r_clr_ptr + 1'b1;
      end
      r_wr_drop <= w_drop_nxt;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (!reset) begin
        if (w_clr_en && (r_clr_ptr == (ADDR_W+1)'(i))) begin
          r_mem[i] <= RESET_VAL;
        end else if (w_wr_acc && (dr == ADDR_W'(i))) begin
          r_mem[i] <= wdata;
        end
      end
    end
  end

  always_comb begin
    w_rd1 = '0;
    w_rd2 = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (sr1 == ADDR_W'(i)) w_rd1 = r_mem[i];
      if (sr2 == ADDR_W'(i)) w_rd2 = r_mem[i];
    end
  end

  reg_bank_read_port #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .ZERO_REG(ZERO_REG)
  ) u_rp1 (
    .clk(clk), .reset(reset), .i_en(w_ready), .i_sr(sr1), .i_wr_acc(w_wr_acc),
    .i_dr(dr), .i_wdata(wdata), .i_mem_data(w_rd1), .o_regd(regd1)
  );

  reg_bank_read_port #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .ZERO_REG(ZERO_REG)
  ) u_rp2 (
    .clk(clk), .reset(reset), .i_en(w_ready), .i_sr(sr2), .i_wr_acc(w_wr_acc),
    .i_dr(dr), .i_wdata(wdata), .i_mem_data(w_rd2), .o_regd(regd2)
  );

  assign ready   = w_ready;
  assign wr_drop = r_wr_drop;

endmodule

`default_nettype wire

// File: tb/tb_reg_bank_param.sv
// tb_reg_bank_param: random + directed stimulus on DEPTH=32 and DEPTH=20 banks vs a behavioural model.
`default_nettype none

module tb_reg_bank_param;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  sr1 = '0, sr2 = '0, dr = '0;
  logic [31:0] wdata = '0;
  logic        write = 1'b0;

  logic [31:0] a_r1 [2];
  logic [31:0] a_r2 [2];
  logic        a_rdy [2];
  logic        a_drop [2];

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  reg_bank_param u_dut32 (
    .clk(clk), .reset(reset), .sr1(sr1), .sr2(sr2), .dr(dr), .wdata(wdata), .write(write),
    .regd1(a_r1[0]), .regd2(a_r2[0]), .ready(a_rdy[0]), .wr_drop(a_drop[0])
  );

  reg_bank_param #(.DEPTH(20)) u_dut20 (
    .clk(clk), .reset(reset), .sr1(sr1), .sr2(sr2), .dr(dr), .wdata(wdata), .write(write),
    .regd1(a_r1[1]), .regd2(a_r2[1]), .ready(a_rdy[1]), .wr_drop(a_drop[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passes++;
  endtask

  // Behavioural model: sweep progress is just "edges since reset", memory is a plain array.
  int          depth [2] = '{32, 20};
  int          cnt [2];
  logic [31:0] m [2][32];
  logic [31:0] e_r1 [2];
  logic [31:0] e_r2 [2];
  logic        e_drop [2];
  bit          started = 0;

  function automatic logic [31:0] model_rd(int k, int s, bit acc);
    if (s == 0 || s >= depth[k]) return 32'd0;
    if (acc && int'(dr) == s) return wdata;
    return m[k][s];
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        cnt[k] = 0; e_r1[k] = 0; e_r2[k] = 0; e_drop[k] = 0;
      end else if (cnt[k] < depth[k]) begin
        m[k][cnt[k]] = 32'd0;
        cnt[k]++;
        e_r1[k] = 0; e_r2[k] = 0;
        e_drop[k] = write;
      end else begin
        bit acc;
        acc = write && (int'(dr) < depth[k]) && (dr != 0);
        e_r1[k] = model_rd(k, int'(sr1), acc);
        e_r2[k] = model_rd(k, int'(sr2), acc);
        e_drop[k] = write && (int'(dr) >= depth[k]);
        if (acc) m[k][dr] = wdata;
      end
    end
    if (reset) started = 1;
  end

  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("regd1[%0d]", k), a_r1[k], e_r1[k]);
        chk($sformatf("regd2[%0d]", k), a_r2[k], e_r2[k]);
        chk($sformatf("ready[%0d]", k), 32'(a_rdy[k]), 32'(cnt[k] >= depth[k]));
        chk($sformatf("wr_drop[%0d]", k), 32'(a_drop[k]), 32'(e_drop[k]));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int n;
    @(negedge clk);
    reset = 1; cyc(); cyc();
    chk("rst_ready32", 32'(a_rdy[0]), 32'd0);
    chk("rst_regd1", a_r1[0], 32'd0);
    reset = 0;
    for (int e = 1; e <= 32; e++) begin
      write = (e == 5); dr = 5'd3; wdata = 32'd99;
      cyc();
      if (e == 5)  chk("clr_drop", 32'(a_drop[0]), 32'd1);
      if (e == 19) chk("sweep20_e19", 32'(a_rdy[1]), 32'd0);
      if (e == 20) chk("sweep20_e20", 32'(a_rdy[1]), 32'd1);
      if (e == 31) chk("sweep32_e31", 32'(a_rdy[0]), 32'd0);
      if (e == 32) chk("sweep32_e32", 32'(a_rdy[0]), 32'd1);
    end
    write = 0; sr1 = 5'd3; cyc();
    chk("clr_write_lost", a_r1[0], 32'd0);

    for (int i = 0; i < 32; i++) begin
      write = 1; dr = 5'(i); wdata = 32'(i * 10); cyc();
    end
    write = 0;
    for (int j = 0; j < 31; j++) begin
      sr1 = 5'(j); sr2 = 5'(j + 1); cyc();
      if (j == 0) chk("zero_reg", a_r1[0], 32'd0);
      if (j == 4) begin
        chk("pair_r1", a_r1[0], 32'd40);
        chk("pair_r2", a_r2[0], 32'd50);
      end
      if (j == 25) chk("pair_r2_oor20", a_r2[1], 32'd0);
    end

    write = 1; dr = 5'd7; sr1 = 5'd7; sr2 = 5'd7; wdata = 32'hDEADBEEF; cyc();
    chk("bypass_r1", a_r1[0], 32'hDEADBEEF);
    chk("bypass_r2", a_r2[1], 32'hDEADBEEF);
    write = 0; cyc();
    chk("bypass_stored", a_r1[0], 32'hDEADBEEF);

    write = 1; dr = 5'd25; wdata = 32'd1; sr1 = 5'd25; cyc();
    chk("oor_drop20", 32'(a_drop[1]), 32'd1);
    chk("oor_read20", a_r1[1], 32'd0);
    chk("oor_nodrop32", 32'(a_drop[0]), 32'd0);
    dr = 5'd0; wdata = 32'd5; sr1 = 5'd0; cyc();
    chk("zero_nodrop", 32'(a_drop[1]), 32'd0);
    write = 0; cyc();
    chk("zero_still0", a_r1[1], 32'd0);

    reset = 1; cyc(); reset = 0;
    for (int e = 0; e < 10; e++) cyc();
    reset = 1; cyc(); reset = 0;
    n = 0;
    while (!a_rdy[0] && n < 40) begin cyc(); n++; end
    chk("midsweep_edges", 32'(n), 32'd32);

    for (int c = 0; c < 2000; c++) begin
      reset = ($urandom_range(0, 255) == 0);
      write = $urandom_range(0, 1);
      dr    = 5'($urandom_range(0, 31));
      sr1   = 5'($urandom_range(0, 31));
      sr2   = ($urandom_range(0, 3) == 0) ? dr : 5'($urandom_range(0, 31));
      wdata = $urandom;
      cyc();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
